vec_mem_scheduler: RTL and testbench

- Sits between the vector dispatch stage and the vector memory unit.
- Buffers decoded load/store requests in a small in-order queue and issues them one at a time as a single-cycle `mem_enable` pulse.
- Holds each request until the matching `read_done`/`store_done` arrives, then issues the next.
- Provides backpressure to dispatch, an occupancy count, and a sticky watchdog error for lost completions.

---
 rtl/vec_mem_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_vec_mem_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_scheduler.sv
// In-order load/store request queue that issues one request at a time to the vector memory unit and waits for its completion.
// Accept->mem_enable is 2 cycles; req_ready = !full from registered occupancy, so a same-cycle dequeue never frees a slot.
module vec_mem_scheduler #(
    parameter  int ADDR_RANGE     = 32768,
    parameter  int DEPTH          = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int AW             = $clog2(ADDR_RANGE) + 2,
    localparam int CW             = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_sew,
    input  logic [2:0]    req_indexed_sew,
    input  logic [1:0]    req_mode,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_stride,
    input  logic [4:0]    req_dest,
    output logic          mem_enable,
    output logic          mem_load,
    output logic          mem_store,
    output logic [2:0]    mem_sew,
    output logic [2:0]    mem_indexed_sew,
    output logic [1:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_stride,
    output logic [4:0]    mem_dest,
    input  logic          read_done,
    input  logic          store_done,
    input  logic [4:0]    done_id,
    output logic [CW-1:0] outstanding,
    output logic          idle,
    output logic          timeout_error
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic          store;
        logic [2:0]    sew;
        logic [2:0]    indexed_sew;
        logic [1:0]    mode;
        logic [AW-1:0] addr;
        logic [AW-1:0] stride;
        logic [4:0]    dest;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    req_t          entries_q [DEPTH];
    req_t          entries_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    req_t          issued_q, issued_d;
    logic          ld_q, ld_d;
    logic          st_q, st_d;

    logic push;
    logic pop;
    logic done_hit;
    logic wd_expire;
    req_t incoming;

    assign incoming = '{store:       req_store,
                        sew:         req_sew,
                        indexed_sew: req_indexed_sew,
                        mode:        req_mode,
                        addr:        req_addr,
                        stride:      req_stride,
                        dest:        req_dest};

    assign push      = req_valid && (count_q != FULL_CNT);
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    // Type must match the issued op as well as the register id.
    assign done_hit  = ((ld_q && read_done) || (st_q && store_done)) && (done_id == issued_q.dest);
    assign wd_expire = (wd_q == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_hit || wd_expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_enable      = (state_q == S_ISSUE);
        mem_load        = ld_q;
        mem_store       = st_q;
        mem_sew         = issued_q.sew;
        mem_indexed_sew = issued_q.indexed_sew;
        mem_mode        = issued_q.mode;
        mem_addr        = issued_q.addr;
        mem_stride      = issued_q.stride;
        mem_dest        = issued_q.dest;
        req_ready       = (count_q != FULL_CNT);
        outstanding     = count_q + CW'(state_q != S_IDLE);
        idle            = (count_q == '0) && (state_q == S_IDLE);
        timeout_error   = err_q;
    end

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        issued_d  = issued_q;
        ld_d      = ld_q;
        st_d      = st_q;
        wd_d      = wd_q;
        err_d     = err_q;

        if (push) begin
            entries_d[wr_ptr_q] = incoming;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            issued_d = entries_q[rd_ptr_q];
            ld_d     = !entries_q[rd_ptr_q].store;
            st_d     = entries_q[rd_ptr_q].store;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (state_q == S_ISSUE) begin
            wd_d = '0;
        end else if (state_q == S_WAIT) begin
            wd_d = wd_q + WW'(1);
            // A completion landing in the expiry cycle takes priority over the error.
            if (wd_expire && !done_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_vec_mem_scheduler.sv
// Randomized and directed bench for vec_mem_scheduler against a queue-based reference model.
module tb_vec_mem_scheduler;
    localparam int ADDR_RANGE = 32768;
    localparam int DEPTH      = 4;
    localparam int TO         = 16;
    localparam int AW         = $clog2(ADDR_RANGE) + 2;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [2:0]    req_sew = '0;
    logic [2:0]    req_indexed_sew = '0;
    logic [1:0]    req_mode = '0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_stride = '0;
    logic [4:0]    req_dest = '0;
    logic          mem_enable, mem_load, mem_store;
    logic [2:0]    mem_sew, mem_indexed_sew;
    logic [1:0]    mem_mode;
    logic [AW-1:0] mem_addr, mem_stride;
    logic [4:0]    mem_dest;
    logic          read_done = 1'b0;
    logic          store_done = 1'b0;
    logic [4:0]    done_id = '0;
    logic [CW-1:0] outstanding;
    logic          idle, timeout_error;

    vec_mem_scheduler #(
        .ADDR_RANGE    (ADDR_RANGE),
        .DEPTH         (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_sew        (req_sew),
        .req_indexed_sew(req_indexed_sew),
        .req_mode       (req_mode),
        .req_addr       (req_addr),
        .req_stride     (req_stride),
        .req_dest       (req_dest),
        .mem_enable     (mem_enable),
        .mem_load       (mem_load),
        .mem_store      (mem_store),
        .mem_sew        (mem_sew),
        .mem_indexed_sew(mem_indexed_sew),
        .mem_mode       (mem_mode),
        .mem_addr       (mem_addr),
        .mem_stride     (mem_stride),
        .mem_dest       (mem_dest),
        .read_done      (read_done),
        .store_done     (store_done),
        .done_id        (done_id),
        .outstanding    (outstanding),
        .idle           (idle),
        .timeout_error  (timeout_error)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of requests plus one in-flight slot.
    // m_age counts cycles since issue: 0 is the issue cycle, 1..TO are wait cycles.
    typedef struct packed {
        bit          store;
        bit [2:0]    sew;
        bit [2:0]    isew;
        bit [1:0]    mode;
        bit [AW-1:0] addr;
        bit [AW-1:0] stride;
        bit [4:0]    dest;
    } mreq_t;

    mreq_t m_q[$];
    mreq_t m_cur;
    bit    m_busy, m_issued, m_err;
    int    m_age;

    task automatic model_reset();
        m_q.delete();
        m_cur    = '0;
        m_busy   = 0;
        m_issued = 0;
        m_err    = 0;
        m_age    = 0;
    endtask

    task automatic model_edge();
        int    sz;
        bit    hit;
        mreq_t nr;
        sz = m_q.size();
        nr = '{store: req_store, sew: req_sew, isew: req_indexed_sew, mode: req_mode,
               addr: req_addr, stride: req_stride, dest: req_dest};
        if (!m_busy) begin
            if (sz > 0) begin
                m_cur    = m_q.pop_front();
                m_busy   = 1;
                m_issued = 1;
                m_age    = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            hit = ((!m_cur.store && read_done) || (m_cur.store && store_done)) && (done_id == m_cur.dest);
            if (hit) begin
                m_busy = 0;
            end else if (m_age == TO) begin
                m_err  = 1;
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
        if (req_valid && sz < DEPTH) m_q.push_back(nr);
    endtask

    task automatic check_outputs();
        check_eq("req_ready",       req_ready,       m_q.size() < DEPTH);
        check_eq("mem_enable",      mem_enable,      m_busy && m_age == 0);
        check_eq("mem_load",        mem_load,        m_issued && !m_cur.store);
        check_eq("mem_store",       mem_store,       m_issued && m_cur.store);
        check_eq("mem_sew",         mem_sew,         m_cur.sew);
        check_eq("mem_indexed_sew", mem_indexed_sew, m_cur.isew);
        check_eq("mem_mode",        mem_mode,        m_cur.mode);
        check_eq("mem_addr",        mem_addr,        m_cur.addr);
        check_eq("mem_stride",      mem_stride,      m_cur.stride);
        check_eq("mem_dest",        mem_dest,        m_cur.dest);
        check_eq("outstanding",     outstanding,     m_q.size() + int'(m_busy));
        check_eq("idle",            idle,            m_q.size() == 0 && !m_busy);
        check_eq("timeout_error",   timeout_error,   m_err);
    endtask

    // Called just after a negedge with inputs for this cycle already driven.
    task automatic step();
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid  = 0;
        read_done  = 0;
        store_done = 0;
        done_id    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        #1;
        model_reset();
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_mem_enable", mem_enable, 0);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_timeout_error", timeout_error, 0);
        check_eq("rst_mem_load", mem_load, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 0;
    endtask

    task automatic set_req(input bit st, input bit [2:0] sew, input bit [2:0] isew, input bit [1:0] mode,
                           input bit [AW-1:0] addr, input bit [AW-1:0] stride, input bit [4:0] dest);
        req_store       = st;
        req_sew         = sew;
        req_indexed_sew = isew;
        req_mode        = mode;
        req_addr        = addr;
        req_stride      = stride;
        req_dest        = dest;
    endtask

    task automatic rand_req();
        set_req(1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                AW'($urandom), AW'($urandom), 5'($urandom));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int    en_seen;
        int    sent;
        int    got[$];
        int    resp_div;
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single load: accept at c, issue at c+2, complete at c+10, idle at c+11.
        repeat (3) step();
        set_req(0, 3'd2, 3'd0, 2'd0, AW'('h100), AW'(4), 5'd5);
        req_valid = 1;
        step();
        req_valid = 0;
        step();
        check_eq("single_enable", mem_enable, 1);
        check_eq("single_load", mem_load, 1);
        check_eq("single_addr", mem_addr, 'h100);
        check_eq("single_dest", mem_dest, 5);
        repeat (8) step();
        read_done = 1;
        done_id   = 5'd5;
        step();
        clear_inputs();
        check_eq("single_idle", idle, 1);

        // Fill: memory silent, 5 handshakes leave 4 queued + 1 in flight.
        do_reset();
        req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            rand_req();
            step();
        end
        check_eq("fill_req_ready", req_ready, 0);
        check_eq("fill_outstanding", outstanding, 5);
        rand_req();
        step();
        check_eq("fill_hold_outstanding", outstanding, 5);
        req_valid = 0;

        // Wrong completions are ignored, including one during the issue cycle.
        do_reset();
        set_req(1, 3'd1, 3'd0, 2'd1, AW'('h2000), AW'(8), 5'd3);
        req_valid = 1;
        step();
        req_valid  = 0;
        step();
        store_done = 1;
        done_id    = 5'd3;
        step();
        store_done = 0;
        read_done  = 1;
        step();
        read_done  = 0;
        store_done = 1;
        done_id    = 5'd4;
        step();
        store_done = 0;
        check_eq("wrong_still_busy", outstanding, 1);
        check_eq("wrong_store", mem_store, 1);
        store_done = 1;
        done_id    = 5'd3;
        step();
        clear_inputs();
        check_eq("wrong_then_idle", idle, 1);

        // Ordering and pointer wrap: 8 requests, immediate completions.
        do_reset();
        sent = 0;
        got.delete();
        for (int c = 0; c < 300 && got.size() < 8; c++) begin
            req_valid = (sent < 8);
            set_req(1'(sent), 3'(sent), 3'd0, 2'd0, AW'(sent * 64), AW'(1), 5'(sent));
            read_done  = 0;
            store_done = 0;
            done_id    = '0;
            if (m_busy && m_age >= 1) begin
                read_done  = !m_cur.store;
                store_done = m_cur.store;
                done_id    = m_cur.dest;
            end
            if (mem_enable) got.push_back(int'(mem_dest));
            if (req_valid && req_ready) sent++;
            step();
        end
        clear_inputs();
        check_eq("order_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            check_eq($sformatf("order_dest%0d", i), got[i], i);
        end

        // Timeout: first load never completes, queued store issues 2 cycles after expiry.
        do_reset();
        set_req(0, 3'd0, 3'd0, 2'd0, AW'('h40), AW'(0), 5'd1);
        req_valid = 1;
        step();
        set_req(1, 3'd0, 3'd0, 2'd0, AW'('h80), AW'(0), 5'd2);
        step();
        req_valid = 0;
        check_eq("to_first_issue", mem_enable, 1);
        repeat (TO) step();
        check_eq("to_not_yet", timeout_error, 0);
        step();
        check_eq("to_error", timeout_error, 1);
        check_eq("to_outstanding", outstanding, 1);
        step();
        check_eq("to_next_issue", mem_enable, 1);
        check_eq("to_next_dest", mem_dest, 2);
        repeat (3) step();
        check_eq("to_sticky", timeout_error, 1);

        // Completion in the expiry cycle wins.
        do_reset();
        set_req(0, 3'd0, 3'd0, 2'd0, AW'('h40), AW'(0), 5'd1);
        req_valid = 1;
        step();
        req_valid = 0;
        step();
        repeat (TO) step();
        read_done = 1;
        done_id   = 5'd1;
        step();
        clear_inputs();
        check_eq("to_late_done_err", timeout_error, 0);
        check_eq("to_late_done_idle", idle, 1);

        // Reset while waiting with two entries queued.
        do_reset();
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            step();
        end
        req_valid = 0;
        check_eq("midrst_before", outstanding, 3);
        do_reset();
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            en_seen += int'(mem_enable);
            step();
        end
        check_eq("midrst_no_issue", en_seen, 0);
        rand_req();
        req_valid = 1;
        step();
        req_valid = 0;
        step();
        check_eq("midrst_new_issue", mem_enable, 1);

        // Random traffic with varying completion rates and occasional resets.
        do_reset();
        for (int c = 0; c < 1800; c++) begin
            resp_div = (c >= 600 && c < 1200) ? 30 : 3;
            if ($urandom_range(0, 399) == 0) do_reset();
            req_valid  = 1'($urandom);
            rand_req();
            read_done  = 0;
            store_done = 0;
            done_id    = 5'($urandom);
            if (m_busy && m_age >= 1 && $urandom_range(0, resp_div - 1) == 0) begin
                read_done  = !m_cur.store;
                store_done = m_cur.store;
                done_id    = m_cur.dest;
            end else if ($urandom_range(0, 3) == 0) begin
                read_done  = 1'($urandom);
                store_done = 1'($urandom);
                if ($urandom_range(0, 1) == 0) done_id = m_cur.dest;
            end
            step();
        end
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
